// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared state encoding and constants for the modular exponentiation sequencer
package mont_pkg;

    localparam int MONT_W   = 512;
    localparam int MONT_ONE = 1;

    typedef enum logic [3:0] {
        IDLE,
        PRE_ISSUE,
        PRE_WAIT,
        SKIP,
        SQR_ISSUE,
        SQR_WAIT,
        MUL_ISSUE,
        MUL_WAIT,
        POST_ISSUE,
        POST_WAIT,
        DONE
    } state_t;

    function automatic logic is_issue(input state_t s);
        return (s == PRE_ISSUE) || (s == SQR_ISSUE) || (s == MUL_ISSUE) || (s == POST_ISSUE);
    endfunction

endpackage

// File: rtl/mont_exp_opsel.sv
// rtl/mont_exp_opsel.sv - picks the multiplier operands for the multiply about to be issued
module mont_exp_opsel
    import mont_pkg::*;
#(
    parameter int W = MONT_W
) (
    input  state_t         state_i,
    input  logic [W-1:0]   x_i,
    input  logic [W-1:0]   r2_i,
    input  logic [W-1:0]   acc_i,
    input  logic [W-1:0]   xm_i,
    output logic [W-1:0]   a_o,
    output logic [W-1:0]   b_o
);

    always_comb begin
        a_o = '0;
        b_o = '0;
        case (state_i)
            PRE_ISSUE: begin
                a_o = x_i;
                b_o = r2_i;
            end
            SQR_ISSUE: begin
                a_o = acc_i;
                b_o = acc_i;
            end
            MUL_ISSUE: begin
                a_o = acc_i;
                b_o = xm_i;
            end
            // Multiplying by plain 1 strips the Montgomery factor R.
            POST_ISSUE: begin
                a_o = acc_i;
                b_o = W'(MONT_ONE);
            end
            default: begin
                a_o = '0;
                b_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/mont_exp_ctrl.sv
// rtl/mont_exp_ctrl.sv - square-and-multiply sequencer driving one Montgomery multiplier core
module mont_exp_ctrl
    import mont_pkg::*;
#(
    parameter int W       = MONT_W,
    parameter int E_WIDTH = 512
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [W-1:0]       in_x,
    input  logic [E_WIDTH-1:0] in_e,
    input  logic [W-1:0]       in_m,
    input  logic [W-1:0]       in_r,
    input  logic [W-1:0]       in_r2,
    output logic [W-1:0]       result,
    output logic               done,
    output logic               busy,
    output logic               mont_start,
    output logic [W-1:0]       mont_a,
    output logic [W-1:0]       mont_b,
    output logic [W-1:0]       mont_m,
    input  logic [W-1:0]       mont_result,
    input  logic               mont_done
);

    localparam int IDX_W = $clog2(E_WIDTH);

    state_t             state_q, state_d;
    logic [W-1:0]       x_q, r_q, r2_q, m_q;
    logic [E_WIDTH-1:0] e_q;
    logic [W-1:0]       acc_q, acc_d, xm_q, xm_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       result_q, mont_a_q, mont_b_q;
    logic               done_q, busy_q, mont_start_q;

    logic               accept, last, bit_set;
    logic [W-1:0]       x_d, r2_d, op_a, op_b;

    assign accept  = (state_q == IDLE) && start;
    assign last    = (idx_q == '0);
    assign bit_set = e_q[idx_q];
    assign x_d     = accept ? in_x  : x_q;
    assign r2_d    = accept ? in_r2 : r2_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        xm_d    = xm_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PRE_ISSUE;
                    idx_d   = IDX_W'(E_WIDTH - 1);
                end
            end
            PRE_ISSUE: state_d = PRE_WAIT;
            PRE_WAIT: begin
                if (mont_done) begin
                    xm_d    = mont_result;
                    state_d = SKIP;
                end
            end
            // Leading zeros cost one cycle each; the first set bit seeds acc with xm.
            SKIP: begin
                if (bit_set) begin
                    acc_d = xm_q;
                    if (last) begin
                        state_d = POST_ISSUE;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = SQR_ISSUE;
                    end
                end else if (last) begin
                    acc_d   = r_q;
                    state_d = POST_ISSUE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            SQR_ISSUE: state_d = SQR_WAIT;
            SQR_WAIT: begin
                if (mont_done) begin
                    acc_d = mont_result;
                    if (bit_set) begin
                        state_d = MUL_ISSUE;
                    end else if (last) begin
                        state_d = POST_ISSUE;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = SQR_ISSUE;
                    end
                end
            end
            MUL_ISSUE: state_d = MUL_WAIT;
            MUL_WAIT: begin
                if (mont_done) begin
                    acc_d = mont_result;
                    if (last) begin
                        state_d = POST_ISSUE;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = SQR_ISSUE;
                    end
                end
            end
            POST_ISSUE: state_d = POST_WAIT;
            POST_WAIT: begin
                if (mont_done) begin
                    acc_d   = mont_result;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    mont_exp_opsel #(.W(W)) u_opsel (
        .state_i (state_d),
        .x_i     (x_d),
        .r2_i    (r2_d),
        .acc_i   (acc_d),
        .xm_i    (xm_d),
        .a_o     (op_a),
        .b_o     (op_b)
    );

    // Outputs are loaded on entry to ISSUE/DONE so start and operands appear in that same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            e_q          <= '0;
            m_q          <= '0;
            r_q          <= '0;
            r2_q         <= '0;
            acc_q        <= '0;
            xm_q         <= '0;
            idx_q        <= '0;
            result_q     <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            mont_start_q <= 1'b0;
            mont_a_q     <= '0;
            mont_b_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            xm_q    <= xm_d;
            idx_q   <= idx_d;
            if (accept) begin
                x_q    <= in_x;
                e_q    <= in_e;
                m_q    <= in_m;
                r_q    <= in_r;
                r2_q   <= in_r2;
                busy_q <= 1'b1;
            end else if (state_q == DONE) begin
                busy_q <= 1'b0;
            end
            mont_start_q <= is_issue(state_d);
            if (is_issue(state_d)) begin
                mont_a_q <= op_a;
                mont_b_q <= op_b;
            end
            done_q <= (state_d == DONE);
            if (state_d == DONE) begin
                result_q <= acc_d;
            end
        end
    end

    assign result     = result_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign mont_start = mont_start_q;
    assign mont_a     = mont_a_q;
    assign mont_b     = mont_b_q;
    assign mont_m     = m_q;

endmodule
